seg7_scan_driver: RTL and testbench

- Display-side consumer for the push-button digit counters: takes NUM_DIGITS 4-bit digit codes and drives a time-multiplexed common-segment 7-segment display, one digit enabled at a time.
- New values are captured on a load strobe and committed only at a frame boundary (no tearing).
- Sits between the counter/control logic and the board display pins, alongside the VGA path.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_scan_timer.sv | 48 ++++
 rtl/seg7_scan_driver.sv | 112 +++++++++++
 tb/tb_seg7_scan_driver.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment decode table for the 7-segment scan driver.
// Segment order is abcdefg, bit6 = a ... bit0 = g, active-high.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;

    localparam seg_t SEG_LUT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic seg_t seg_decode(input logic [3:0] code);
        return SEG_LUT[code];
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot/digit timebase for the scan driver: counts SCAN_DIV cycles per digit,
// flags the anti-ghost guard window and the frame wrap (last slot of last digit).
module seg7_scan_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 16,
    parameter int IDX_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic [IDX_W-1:0] digit_idx,
    output logic             slot_guard,
    output logic             frame_wrap
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0] digit_idx_q, digit_idx_d;
    logic             slot_end;

    always_comb begin
        slot_end    = (scan_cnt_q == CNT_LAST);
        frame_wrap  = slot_end && (digit_idx_q == IDX_LAST);
        slot_guard  = (scan_cnt_q < GUARD_C);
        scan_cnt_d  = slot_end ? '0 : scan_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (slot_end) begin
            digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    assign digit_idx = digit_idx_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver with frame-synchronous value commit.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    update_done
);

    localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    logic [IDX_W-1:0]        digit_idx;
    logic                    slot_guard;
    logic                    frame_wrap;

    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pending_flag_q, pending_flag_d;
    seg_t                    seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    update_done_q, update_done_d;

    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              cur_code;
    logic                    dig_blank;

    seg7_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .GUARD      (GUARD),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .digit_idx  (digit_idx),
        .slot_guard (slot_guard),
        .frame_wrap (frame_wrap)
    );

    // A load landing on the frame wrap bypasses pending and commits directly.
    always_comb begin
        active_d       = active_q;
        pending_d      = pending_q;
        pending_flag_d = pending_flag_q;
        update_done_d  = 1'b0;
        if (load) begin
            pending_d      = value_in;
            pending_flag_d = 1'b1;
        end
        if (frame_wrap && (load || pending_flag_q)) begin
            active_d       = load ? value_in : pending_q;
            pending_flag_d = 1'b0;
            update_done_d  = 1'b1;
        end
    end

    always_comb begin
        lz_mask = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
            lz_mask[k] = ((active_q >> (4 * k)) == '0);
        end
`endif
    end

    always_comb begin
        cur_code  = '0;
        dig_blank = 1'b0;
        an_d      = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx == IDX_W'(k)) begin
                cur_code  = active_q[4*k +: 4];
                dig_blank = blank_mask[k] | lz_mask[k];
                an_d[k]   = 1'b1;
            end
        end
        seg_d = (slot_guard || dig_blank) ? SEG_BLANK : seg_decode(cur_code);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q       <= '0;
            pending_q      <= '0;
            pending_flag_q <= 1'b0;
            seg_q          <= SEG_BLANK;
            an_q           <= '0;
            update_done_q  <= 1'b0;
        end else begin
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_flag_q <= pending_flag_d;
            seg_q          <= seg_d;
            an_q           <= an_d;
            update_done_q  <= update_done_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign update_done = update_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (NUM_DIGITS=4, SCAN_DIV=4, GUARD=1)
// against a cycle-count based reference model; honours SEG7_LEADING_ZERO_BLANK_EN.
module tb_seg7_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int GRD = 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [4*N-1:0] value_in = '0;
    logic           load = 1'b0;
    logic [N-1:0]   blank_mask = '0;
    logic [6:0]     seg;
    logic [N-1:0]   an;
    logic           update_done;

    int checks   = 0;
    int failures = 0;

    logic [6:0] ref_lut [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    int             m_tick;
    logic [4*N-1:0] m_active, m_pending;
    logic           m_pflag;
    logic [6:0]     exp_seg;
    logic [N-1:0]   exp_an;
    logic           exp_upd;

    seg7_scan_driver #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (DIV),
        .GUARD      (GRD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value_in    (value_in),
        .load        (load),
        .blank_mask  (blank_mask),
        .seg         (seg),
        .an          (an),
        .update_done (update_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference: slot position and digit follow directly from cycles since reset.
    task automatic model_edge();
        int  pos, dig;
        bit  blank, boundary;
        if (reset) begin
            m_tick = 0; m_active = '0; m_pending = '0; m_pflag = 1'b0;
            exp_seg = '0; exp_an = '0; exp_upd = 1'b0;
        end else begin
            pos = m_tick % DIV;
            dig = (m_tick / DIV) % N;
            exp_an = N'(1) << dig;
            blank = (pos < GRD) || blank_mask[dig];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (dig > 0 && (m_active >> (4 * dig)) == 0) blank = 1'b1;
`endif
            exp_seg = blank ? 7'h00 : ref_lut[(m_active >> (4 * dig)) & 4'hF];
            boundary = (pos == DIV - 1) && (dig == N - 1);
            exp_upd = 1'b0;
            if (boundary && load) begin
                m_active = value_in; m_pending = value_in; m_pflag = 1'b0; exp_upd = 1'b1;
            end else if (boundary && m_pflag) begin
                m_active = m_pending; m_pflag = 1'b0; exp_upd = 1'b1;
            end else if (load) begin
                m_pending = value_in; m_pflag = 1'b1;
            end
            m_tick++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("seg", 32'(seg), 32'(exp_seg));
        check("an", 32'(an), 32'(exp_an));
        check("update_done", 32'(update_done), 32'(exp_upd));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Advance until the next edge falls on tick phase ph within the 16-cycle frame.
    task automatic to_phase(input int ph);
        int guard_cnt = 0;
        while ((m_tick % (DIV * N)) != ph && guard_cnt < 64) begin
            cycle();
            guard_cnt++;
        end
        check("phase_reached", 32'(m_tick % (DIV * N)), 32'(ph));
    endtask

    task automatic pulse_load(input logic [4*N-1:0] v);
        value_in = v; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        run(20);

        to_phase(5);  pulse_load(16'h9A30); run(30);
        to_phase(2);  pulse_load(16'h1111);
        to_phase(6);  pulse_load(16'h2222); run(30);
        to_phase(15); pulse_load(16'h0005); run(20);

        to_phase(3);  pulse_load(16'h1234);
        to_phase(0);  blank_mask = 4'b0100; run(32); blank_mask = '0;
        to_phase(7);  pulse_load(16'h0070); run(32);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            load = ($urandom_range(0, 7) == 0);
            if (load) value_in = ($urandom_range(0, 3) == 0) ? 16'(($urandom & 32'hFF)) : 16'($urandom);
            if ($urandom_range(0, 49) == 0) blank_mask = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom);
            cycle();
        end
        reset = 1'b0; load = 1'b0;
        run(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
